mac_seq: RTL and testbench

- Sequential fixed-point multiply-accumulate stage directly upstream of the perceptron's two-input adder.
- Consumes a stream of NIN (input, weight) pairs in signed Q(DWIDTH-FRAC).FRAC format and accumulates their products.
- Presents the dot-product result with a one-cycle out_valid pulse; the downstream adder then adds the bias.

---
 rtl/ann_fxp_pkg.sv | 16 +
 rtl/fxp_mul.sv | 43 ++++
 rtl/mac_seq.sv | 98 +++++++++
 tb/tb_mac_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_fxp_pkg.sv
// Shared fixed-point defaults, saturation limits and MAC state encoding.
package ann_fxp_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_FRAC   = 24;

    localparam logic signed [DEF_DWIDTH-1:0] FXP_MAX = {1'b0, {(DEF_DWIDTH-1){1'b1}}};
    localparam logic signed [DEF_DWIDTH-1:0] FXP_MIN = {1'b1, {(DEF_DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC,
// then wrap to DWIDTH, or saturate first when MAC_SAT_EN is defined.
module fxp_mul
    import ann_fxp_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [DWIDTH-1:0] x,
    input  logic signed [DWIDTH-1:0] w,
    output logic signed [DWIDTH-1:0] prod
);

    logic signed [2*DWIDTH-1:0] x_ext;
    logic signed [2*DWIDTH-1:0] w_ext;
    logic signed [2*DWIDTH-1:0] full;
    logic signed [2*DWIDTH-1:0] shifted;

    assign x_ext   = {{DWIDTH{x[DWIDTH-1]}}, x};
    assign w_ext   = {{DWIDTH{w[DWIDTH-1]}}, w};
    assign full    = x_ext * w_ext;
    // Arithmetic shift truncates toward minus infinity.
    assign shifted = full >>> FRAC;

`ifdef MAC_SAT_EN
    localparam logic signed [2*DWIDTH-1:0] WIDE_MAX = {{(DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [2*DWIDTH-1:0] WIDE_MIN = {{(DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    always_comb begin
        prod = shifted[DWIDTH-1:0];
        if (shifted > WIDE_MAX) begin
            prod = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (shifted < WIDE_MIN) begin
            prod = {1'b1, {(DWIDTH-1){1'b0}}};
        end
    end
`else
    logic unused_high;
    assign unused_high = ^shifted[2*DWIDTH-1:DWIDTH];
    assign prod        = shifted[DWIDTH-1:0];
`endif

endmodule

// File: rtl/mac_seq.sv
// Sequential fixed-point MAC: accumulates NIN x*w products, pulses out_valid once.
// Optional MAC_SAT_EN saturates the product and the accumulation instead of wrapping.
module mac_seq
    import ann_fxp_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int NIN    = 4,
    parameter int CNTW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] x,
    input  logic signed [DWIDTH-1:0] w,
    output logic signed [DWIDTH-1:0] acc_out,
    output logic                     out_valid,
    output logic                     busy,
    output state_t                   fsm_state
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NIN - 1);

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
    // in_ready is a pure decode of the registered state, so it never depends on in_valid.
    state_t                   state_q;
    state_t                   next_state;
    logic        [CNTW-1:0]   count;
    logic signed [DWIDTH-1:0] acc;
    logic signed [DWIDTH-1:0] acc_next;
    logic signed [DWIDTH-1:0] prod;
    logic                     accept;
    logic                     run_start;

    fxp_mul #(.DWIDTH(DWIDTH), .FRAC(FRAC)) u_mul (
        .x    (x),
        .w    (w),
        .prod (prod)
    );

    assign accept    = (state_q == ACC) && in_valid;
    assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start;

`ifdef MAC_SAT_EN
    logic signed [DWIDTH:0] sum_ext;
    assign sum_ext = {acc[DWIDTH-1], acc} + {prod[DWIDTH-1], prod};

    always_comb begin
        acc_next = sum_ext[DWIDTH-1:0];
        if (sum_ext[DWIDTH] != sum_ext[DWIDTH-1]) begin
            acc_next = sum_ext[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                       : {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_next = acc + prod;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (start) next_state = ACC;
            ACC:     if (in_valid && (count == LAST_CNT)) next_state = DONE;
            DONE:    next_state = start ? ACC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
        end else if (run_start) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= count + CNTW'(1);
        end
    end

    assign acc_out   = acc;
    assign in_ready  = (state_q == ACC);
    assign busy      = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: hand-computed Q8.24 dot products, gaps, reset abort, back-to-back runs.
module tb_mac_seq;
    import ann_fxp_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] w;
    logic [31:0] acc_out;
    logic        out_valid;
    logic        busy;
    state_t      fsm_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_ovf;

    mac_seq #(.DWIDTH(32), .FRAC(24), .NIN(4), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] xv, input logic [31:0] wv);
        in_valid = 1'b1;
        x        = xv;
        w        = wv;
        tick();
        in_valid = 1'b0;
        x        = '0;
        w        = '0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        w        = '0;
        #2;
        check("rst_acc_out",   acc_out,   32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready",  {31'b0, in_ready},  32'h0);
        check("rst_busy",      {31'b0, busy},      32'h0);
        check("rst_state",     {30'b0, fsm_state}, 32'h0);
        #10 rst = 1'b1;
        tick();

        // in_valid outside ACC is ignored.
        in_valid = 1'b1; x = 32'h01000000; w = 32'h01000000;
        tick(); tick();
        in_valid = 1'b0;
        check("idle_ignore_acc",  acc_out, 32'h0);
        check("idle_ignore_busy", {31'b0, busy}, 32'h0);

        // Run 1: consecutive pairs, result 0.75.
        begin_run();
        check("r1_in_ready", {31'b0, in_ready}, 32'h1);
        check("r1_busy",     {31'b0, busy},     32'h1);
        send(32'h01000000, 32'h00800000);
        check("r1_acc_p1", acc_out, 32'h00800000);
        send(32'h02000000, 32'h00400000);
        check("r1_acc_p2", acc_out, 32'h01000000);
        send(32'hFF000000, 32'h00800000);
        check("r1_no_ov_p3", {31'b0, out_valid}, 32'h0);
        send(32'h00800000, 32'h00800000);
        check("r1_out_valid", {31'b0, out_valid}, 32'h1);
        check("r1_acc_out",   acc_out, 32'h00C00000);
        check("r1_busy_done", {31'b0, busy}, 32'h0);
        tick();
        check("r1_pulse_end", {31'b0, out_valid}, 32'h0);
        check("r1_idle",      {30'b0, fsm_state}, 32'h0);
        check("r1_acc_held",  acc_out, 32'h00C00000);

        // Run 2: 3-cycle in_valid gap between pairs 2 and 3.
        begin_run();
        check("r2_cleared", acc_out, 32'h0);
        send(32'h01000000, 32'h00800000);
        send(32'h02000000, 32'h00400000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r2_gap_ready", {31'b0, in_ready},  32'h1);
            check("r2_gap_no_ov", {31'b0, out_valid}, 32'h0);
        end
        send(32'hFF000000, 32'h00800000);
        check("r2_ready_p3", {31'b0, in_ready}, 32'h1);
        send(32'h00800000, 32'h00800000);
        check("r2_out_valid", {31'b0, out_valid}, 32'h1);
        check("r2_acc_out",   acc_out, 32'h00C00000);
        tick();
        check("r2_pulse_end", {31'b0, out_valid}, 32'h0);

        // Run 3: negative product truncates toward minus infinity.
        begin_run();
        send(32'hFFFFFFFF, 32'h00800000);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        check("neg_out_valid", {31'b0, out_valid}, 32'h1);
        check("neg_acc_out",   acc_out, 32'hFFFFFFFF);
        tick();

        // Run 4: 100.0 * 1.5 overflows the Q8.24 range.
`ifdef MAC_SAT_EN
        exp_ovf = 32'h7FFFFFFF;
`else
        exp_ovf = 32'h96000000;
`endif
        begin_run();
        send(32'h64000000, 32'h01800000);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        check("ovf_out_valid", {31'b0, out_valid}, 32'h1);
        check("ovf_acc_out",   acc_out, exp_ovf);
        tick();

        // Run 5: asynchronous reset after two accepts aborts the run.
        begin_run();
        send(32'h01000000, 32'h00800000);
        send(32'h02000000, 32'h00400000);
        check("abort_pre_acc", acc_out, 32'h01000000);
        #3 rst = 1'b0;
        #1;
        check("abort_acc",   acc_out, 32'h0);
        check("abort_ready", {31'b0, in_ready},  32'h0);
        check("abort_busy",  {31'b0, busy},      32'h0);
        check("abort_ov",    {31'b0, out_valid}, 32'h0);
        tick();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_ov", {31'b0, out_valid}, 32'h0);
            check("abort_idle",  {30'b0, fsm_state}, 32'h0);
        end
        begin_run();
        send(32'h01000000, 32'h00800000);
        send(32'h02000000, 32'h00400000);
        send(32'hFF000000, 32'h00800000);
        send(32'h00800000, 32'h00800000);
        check("post_abort_ov",  {31'b0, out_valid}, 32'h1);
        check("post_abort_acc", acc_out, 32'h00C00000);
        tick();

        // Run 6: start held through ACC, then honoured in DONE for a back-to-back run.
        start = 1'b1;
        tick();
        in_valid = 1'b1;
        x = 32'h01000000; w = 32'h00800000; tick();
        x = 32'h02000000; w = 32'h00400000; tick();
        check("hold_busy", {31'b0, busy}, 32'h1);
        x = 32'hFF000000; w = 32'h00800000; tick();
        x = 32'h00800000; w = 32'h00800000; tick();
        in_valid = 1'b0;
        check("hold_out_valid", {31'b0, out_valid}, 32'h1);
        check("hold_acc_out",   acc_out, 32'h00C00000);
        tick();
        start = 1'b0;
        check("b2b_in_ready", {31'b0, in_ready},  32'h1);
        check("b2b_no_ov",    {31'b0, out_valid}, 32'h0);
        check("b2b_cleared",  acc_out, 32'h0);
        send(32'hFFFFFFFF, 32'h00800000);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        check("b2b_out_valid", {31'b0, out_valid}, 32'h1);
        check("b2b_acc_out",   acc_out, 32'hFFFFFFFF);
        tick();
        check("b2b_pulse_end", {31'b0, out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
